// File: rtl/ili9488_window_writer.sv
// ili9488_window_writer: turns a display window plus a stream of 8-bit
// grayscale pixels into the ILI9488 byte sequence
//   0x2A x0 x1, 0x2B y0 y1, 0x2C, then {p[7:2],2'b00} x3 per pixel,
// handing one byte at a time to the downstream SPI byte driver.
// Optional build macro: ILI_NOP_TERMINATE_EN -- append a NOP (0x00, dc=0)
// after the last pixel so the Memory Write is closed explicitly.
module ili9488_window_writer #(
  parameter int COORD_W = 9,
  parameter int CNT_W   = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] y1,
  input  logic [7:0]         pix_data,
  input  logic               pix_valid,
  output logic               pix_ready,
  output logic               drv_load,
  output logic [7:0]         drv_data,
  output logic               drv_dc,
  input  logic               drv_ack,
  input  logic               drv_done,
  output logic               busy,
  output logic               done,
  output logic               err
);

  typedef enum logic [3:0] {
    IDLE,
    HDR_SEND,
    HDR_GAP,
    PIX_WAIT,
    PIX_SEND,
    PIX_GAP,
    FIN
`ifdef ILI_NOP_TERMINATE_EN
    ,
    NOP_SEND,
    NOP_GAP
`endif
  } state_t;

  localparam logic [3:0] HDR_LAST = 4'd10;

  // Where the FSM goes once the final pixel byte has been handed off.
`ifdef ILI_NOP_TERMINATE_EN
  localparam state_t AFTER_LAST_PIX = NOP_SEND;
`else
  localparam state_t AFTER_LAST_PIX = FIN;
`endif

  state_t               state_q, state_d;
  logic [COORD_W-1:0]   x0_q, x1_q, y0_q, y1_q;
  logic [CNT_W-1:0]     total_q, count_q;
  logic [3:0]           hdr_idx_q;
  logic [1:0]           sub_q;
  logic [7:0]           pix_q;
  logic                 err_q;

  logic                 window_ok;
  logic                 gap_done;
  logic [CNT_W-1:0]     count_inc;
  logic [CNT_W-1:0]     w_span, h_span;
  logic [15:0]          x0_w, x1_w, y0_w, y1_w;
  logic [8:0]           hdr_byte;

  assign window_ok = (x1 >= x0) && (y1 >= y0);
  // The driver reports the byte gone only when done is high and ack has dropped.
  assign gap_done  = drv_done && !drv_ack;
  assign count_inc = count_q + CNT_W'(1);
  assign w_span    = CNT_W'(x1) - CNT_W'(x0) + CNT_W'(1);
  assign h_span    = CNT_W'(y1) - CNT_W'(y0) + CNT_W'(1);
  assign x0_w      = 16'(x0_q);
  assign x1_w      = 16'(x1_q);
  assign y0_w      = 16'(y0_q);
  assign y1_w      = 16'(y1_q);

  // Header byte lookup as {dc, data}, indexed by hdr_idx.
  always_comb begin
    // NOTE: every variable gets a default before the case so no latch is inferred.
    hdr_byte = 9'h000;
    case (hdr_idx_q)
      4'd0:    hdr_byte = {1'b0, 8'h2A};
      4'd1:    hdr_byte = {1'b1, x0_w[15:8]};
      4'd2:    hdr_byte = {1'b1, x0_w[7:0]};
      4'd3:    hdr_byte = {1'b1, x1_w[15:8]};
      4'd4:    hdr_byte = {1'b1, x1_w[7:0]};
      4'd5:    hdr_byte = {1'b0, 8'h2B};
      4'd6:    hdr_byte = {1'b1, y0_w[15:8]};
      4'd7:    hdr_byte = {1'b1, y0_w[7:0]};
      4'd8:    hdr_byte = {1'b1, y1_w[15:8]};
      4'd9:    hdr_byte = {1'b1, y1_w[7:0]};
      4'd10:   hdr_byte = {1'b0, 8'h2C};
      default: hdr_byte = 9'h000;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_d   = state_q;
    pix_ready = 1'b0;
    drv_load  = 1'b0;
    drv_data  = 8'h00;
    drv_dc    = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start && window_ok) state_d = HDR_SEND;
      end
      HDR_SEND: begin
        drv_load = 1'b1;
        {drv_dc, drv_data} = hdr_byte;
        if (drv_ack) state_d = HDR_GAP;
      end
      HDR_GAP: begin
        {drv_dc, drv_data} = hdr_byte;
        if (gap_done) state_d = (hdr_idx_q == HDR_LAST) ? PIX_WAIT : HDR_SEND;
      end
      PIX_WAIT: begin
        pix_ready = 1'b1;
        if (pix_valid) state_d = PIX_SEND;
      end
      PIX_SEND: begin
        drv_load = 1'b1;
        drv_dc   = 1'b1;
        drv_data = {pix_q[7:2], 2'b00};
        if (drv_ack) state_d = PIX_GAP;
      end
      PIX_GAP: begin
        drv_dc   = 1'b1;
        drv_data = {pix_q[7:2], 2'b00};
        if (gap_done) begin
          if (sub_q != 2'd2)            state_d = PIX_SEND;
          else if (count_inc == total_q) state_d = AFTER_LAST_PIX;
          else                          state_d = PIX_WAIT;
        end
      end
`ifdef ILI_NOP_TERMINATE_EN
      NOP_SEND: begin
        drv_load = 1'b1;
        if (drv_ack) state_d = NOP_GAP;
      end
      NOP_GAP: begin
        if (gap_done) state_d = FIN;
      end
`endif
      FIN: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Window latch, pixel/byte counters, and the rejected-start pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x0_q      <= '0;
      x1_q      <= '0;
      y0_q      <= '0;
      y1_q      <= '0;
      total_q   <= '0;
      count_q   <= '0;
      hdr_idx_q <= '0;
      sub_q     <= '0;
      pix_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      err_q <= (state_q == IDLE) && start && !window_ok;
      case (state_q)
        IDLE: begin
          if (start && window_ok) begin
            x0_q      <= x0;
            x1_q      <= x1;
            y0_q      <= y0;
            y1_q      <= y1;
            total_q   <= w_span * h_span;
            count_q   <= '0;
            hdr_idx_q <= '0;
          end
        end
        HDR_GAP: begin
          if (gap_done && hdr_idx_q != HDR_LAST) hdr_idx_q <= hdr_idx_q + 4'd1;
        end
        PIX_WAIT: begin
          if (pix_valid) begin
            pix_q <= pix_data;
            sub_q <= 2'd0;
          end
        end
        PIX_GAP: begin
          if (gap_done) begin
            if (sub_q == 2'd2) count_q <= count_inc;
            else               sub_q   <= sub_q + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign err = err_q;

endmodule

// File: tb/tb_ili9488_window_writer.sv
// Directed self-checking bench for ili9488_window_writer. A behavioural SPI
// byte driver captures every handed-off byte as {dc,data}; each test compares
// that stream against hand-written expected bytes.
module tb_ili9488_window_writer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [8:0] x0, x1, y0, y1;
  logic [7:0] pix_data;
  logic       pix_valid;
  logic       pix_ready;
  logic       drv_load;
  logic [7:0] drv_data;
  logic       drv_dc;
  logic       drv_ack;
  logic       drv_done;
  logic       busy;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;
  int stab_err = 0;
  int r_done, r_to, r_bad;
  logic r_lat;
  logic [8:0] cap[$];
  logic [8:0] exp_q[$];

  ili9488_window_writer #(.COORD_W(9), .CNT_W(18)) dut (
    .clk(clk), .rst(rst), .start(start),
    .x0(x0), .x1(x1), .y0(y0), .y1(y1),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .drv_load(drv_load), .drv_data(drv_data), .drv_dc(drv_dc),
    .drv_ack(drv_ack), .drv_done(drv_done),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Behavioural byte driver: holds ack off for one cycle to test data
  // stability, acks for one cycle, then reports done two cycles later.
  initial begin
    logic [8:0] b;
    drv_ack  = 1'b0;
    drv_done = 1'b1;
    forever begin
      @(negedge clk);
      if (drv_load === 1'b1 && rst === 1'b0) begin
        b = {drv_dc, drv_data};
        @(negedge clk);
        if (!rst && (drv_load !== 1'b1 || {drv_dc, drv_data} !== b)) stab_err++;
        cap.push_back(b);
        drv_ack  = 1'b1;
        drv_done = 1'b0;
        @(negedge clk);
        drv_ack = 1'b0;
        if (!rst && drv_load !== 1'b0) stab_err++;
        @(negedge clk);
        drv_done = 1'b1;
      end
    end
  end

  // Start one window, feed n pixels (optionally stalling before each),
  // optionally fire a second start once dup_at bytes have gone out.
  task automatic run_window(input logic [8:0] wx0, wx1, wy0, wy1,
                            input logic [7:0] p0, p1, p2, p3,
                            input int n, input int stall, input int dup_at);
    logic [7:0] px[4];
    px = '{p0, p1, p2, p3};
    r_done = 0; r_to = 0; r_bad = 0; stab_err = 0;
    cap.delete();
    @(negedge clk);
    x0 = wx0; x1 = wx1; y0 = wy0; y1 = wy1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    r_lat = drv_load;
    fork
      begin : feed
        for (int i = 0; i < n; i++) begin
          int g;
          g = 0;
          while (pix_ready !== 1'b1 && g < 2000) begin @(negedge clk); g++; end
          if (g >= 2000) r_to++;
          for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            if (pix_ready !== 1'b1 || drv_load !== 1'b0) r_bad++;
          end
          pix_data  = px[i];
          pix_valid = 1'b1;
          @(negedge clk);
          pix_valid = 1'b0;
        end
      end
      begin : watch
        int after;
        after = -1;
        for (int c = 0; c < 3000; c++) begin
          @(negedge clk);
          if (done === 1'b1) r_done++;
          if (r_done > 0 && after < 0) after = c;
          if (after >= 0 && c - after >= 10) break;
        end
        if (r_done == 0) r_to++;
      end
      begin : dup
        if (dup_at > 0) begin
          int g;
          g = 0;
          while (cap.size() < dup_at && g < 2000) begin @(negedge clk); g++; end
          x0 = 9'd3; x1 = 9'd8; y0 = 9'd4; y1 = 9'd9; start = 1'b1;
          @(negedge clk);
          start = 1'b0;
          if (err !== 1'b0) r_bad++;
        end
      end
    join
  endtask

  task automatic set_exp_1x1();
    exp_q = '{9'h02A, 9'h100, 9'h100, 9'h100, 9'h100,
              9'h02B, 9'h100, 9'h100, 9'h100, 9'h100,
              9'h02C, 9'h1FC, 9'h1FC, 9'h1FC};
`ifdef ILI_NOP_TERMINATE_EN
    exp_q.push_back(9'h000);
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_data = 8'h00;
    x0 = '0; x1 = '0; y0 = '0; y1 = '0;
    #2;
    checks++;
    if ({pix_ready, drv_load, drv_data, drv_dc, busy, done, err} !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 0", {pix_ready, drv_load, drv_data, drv_dc, busy, done, err});
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || drv_load !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b drv_load=%b want 0 0", busy, drv_load);
    end
  endtask

  task automatic test_1x1();
    run_window(9'd0, 9'd0, 9'd0, 9'd0, 8'hFF, 8'h00, 8'h00, 8'h00, 1, 0, 0);
    set_exp_1x1();
    checks++;
    if (r_lat !== 1'b1) begin errors++; $display("FAIL 1x1_latency: drv_load=%b want 1", r_lat); end
    checks++;
    if (cap.size() != exp_q.size()) begin
      errors++; $display("FAIL 1x1_len: got %0d want %0d", cap.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
      checks++;
      if (cap[i] !== exp_q[i]) begin
        errors++; $display("FAIL 1x1_byte%0d: got %h want %h", i, cap[i], exp_q[i]);
      end
    end
    checks++;
    if (r_done != 1 || r_to != 0) begin
      errors++; $display("FAIL 1x1_done: pulses=%0d timeouts=%0d want 1 0", r_done, r_to);
    end
    checks++;
    if (busy !== 1'b0 || stab_err != 0) begin
      errors++; $display("FAIL 1x1_busy_stab: busy=%b stab_err=%0d want 0 0", busy, stab_err);
    end
  endtask

  task automatic test_edge_coords();
    run_window(9'd319, 9'd319, 9'd1, 9'd2, 8'h83, 8'h40, 8'h00, 8'h00, 2, 0, 0);
    exp_q = '{9'h02A, 9'h101, 9'h13F, 9'h101, 9'h13F,
              9'h02B, 9'h100, 9'h101, 9'h100, 9'h102,
              9'h02C, 9'h180, 9'h180, 9'h180, 9'h140, 9'h140, 9'h140};
`ifdef ILI_NOP_TERMINATE_EN
    exp_q.push_back(9'h000);
`endif
    checks++;
    if (cap.size() != exp_q.size()) begin
      errors++; $display("FAIL edge_len: got %0d want %0d", cap.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
      checks++;
      if (cap[i] !== exp_q[i]) begin
        errors++; $display("FAIL edge_byte%0d: got %h want %h", i, cap[i], exp_q[i]);
      end
    end
    checks++;
    if (r_done != 1 || r_to != 0 || stab_err != 0) begin
      errors++; $display("FAIL edge_done: pulses=%0d timeouts=%0d stab=%0d want 1 0 0", r_done, r_to, stab_err);
    end
  endtask

  task automatic test_bad_window();
    int bad;
    bad = 0;
    cap.delete();
    @(negedge clk);
    x0 = 9'd5; x1 = 9'd4; y0 = 9'd0; y1 = 9'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL bad_err_pulse: got %b want 1", err); end
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL bad_err_width: got %b want 0", err); end
    for (int c = 0; c < 20; c++) begin
      if (drv_load !== 1'b0 || busy !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0 || cap.size() != 0) begin
      errors++; $display("FAIL bad_no_load: bad_cycles=%0d bytes=%0d want 0 0", bad, cap.size());
    end
  endtask

  task automatic test_stall();
    run_window(9'd0, 9'd1, 9'd0, 9'd1, 8'h11, 8'h22, 8'h33, 8'hFF, 4, 20, 0);
    exp_q = '{9'h02A, 9'h100, 9'h100, 9'h100, 9'h101,
              9'h02B, 9'h100, 9'h100, 9'h100, 9'h101,
              9'h02C, 9'h110, 9'h110, 9'h110, 9'h120, 9'h120, 9'h120,
              9'h130, 9'h130, 9'h130, 9'h1FC, 9'h1FC, 9'h1FC};
`ifdef ILI_NOP_TERMINATE_EN
    exp_q.push_back(9'h000);
`endif
    checks++;
    if (cap.size() != exp_q.size()) begin
      errors++; $display("FAIL stall_len: got %0d want %0d", cap.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
      checks++;
      if (cap[i] !== exp_q[i]) begin
        errors++; $display("FAIL stall_byte%0d: got %h want %h", i, cap[i], exp_q[i]);
      end
    end
    checks++;
    if (r_bad != 0) begin errors++; $display("FAIL stall_ready: bad_cycles=%0d want 0", r_bad); end
    checks++;
    if (r_done != 1 || r_to != 0 || stab_err != 0) begin
      errors++; $display("FAIL stall_done: pulses=%0d timeouts=%0d stab=%0d want 1 0 0", r_done, r_to, stab_err);
    end
  endtask

  task automatic test_back_to_back();
    run_window(9'd0, 9'd0, 9'd0, 9'd0, 8'hFF, 8'h00, 8'h00, 8'h00, 1, 0, 3);
    set_exp_1x1();
    checks++;
    if (cap.size() != exp_q.size()) begin
      errors++; $display("FAIL dup_len: got %0d want %0d", cap.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
      checks++;
      if (cap[i] !== exp_q[i]) begin
        errors++; $display("FAIL dup_byte%0d: got %h want %h", i, cap[i], exp_q[i]);
      end
    end
    checks++;
    if (r_bad != 0 || r_done != 1 || r_to != 0) begin
      errors++; $display("FAIL dup_ignored: err_seen=%0d pulses=%0d timeouts=%0d want 0 1 0", r_bad, r_done, r_to);
    end
  endtask

  task automatic test_reset_mid();
    int g;
    cap.delete();
    @(negedge clk);
    x0 = 9'd0; x1 = 9'd1; y0 = 9'd0; y1 = 9'd0; start = 1'b1;
    pix_data = 8'h55; pix_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    g = 0;
    while (cap.size() < 14 && g < 2000) begin @(negedge clk); g++; end
    while (drv_load !== 1'b0 && g < 2000) begin @(negedge clk); g++; end
    while (drv_load !== 1'b1 && g < 2000) begin @(negedge clk); g++; end
    checks++;
    if (g >= 2000) begin errors++; $display("FAIL rstmid_reach: timeout waiting for pixel 1 send"); end
    rst = 1'b1;
    #1;
    checks++;
    if ({pix_ready, drv_load, drv_data, drv_dc, busy, done, err} !== 14'd0) begin
      errors++;
      $display("FAIL rstmid_outputs: got %b want 0", {pix_ready, drv_load, drv_data, drv_dc, busy, done, err});
    end
    pix_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    run_window(9'd0, 9'd0, 9'd0, 9'd0, 8'hFF, 8'h00, 8'h00, 8'h00, 1, 0, 0);
    set_exp_1x1();
    checks++;
    if (cap.size() == 0 || cap[0] !== 9'h02A) begin
      errors++; $display("FAIL rstmid_first: got %h want 02a", (cap.size() == 0) ? 9'h1FF : cap[0]);
    end
    checks++;
    if (cap.size() != exp_q.size()) begin
      errors++; $display("FAIL rstmid_len: got %0d want %0d", cap.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
      checks++;
      if (cap[i] !== exp_q[i]) begin
        errors++; $display("FAIL rstmid_byte%0d: got %h want %h", i, cap[i], exp_q[i]);
      end
    end
    checks++;
    if (r_done != 1 || r_to != 0) begin
      errors++; $display("FAIL rstmid_done: pulses=%0d timeouts=%0d want 1 0", r_done, r_to);
    end
  endtask

  initial begin
    test_reset();
    test_1x1();
    test_edge_coords();
    test_bad_window();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
